// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer with HI/LO registers, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish once no multiplier bits remain.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  input  logic             hilo_rd_i,
  input  logic             wr_hi_i,
  input  logic             wr_lo_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: start_i is accepted only on a clock edge where the unit is idle
  // and cancel_i is low; otherwise decode keeps it asserted (stalled) and retries.
  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] mul_sum, prod_fix;
  logic [WIDTH:0]     rem_sh, trial;
  logic               div_ok;
  logic [WIDTH-1:0]   rem_nx, quo_nx, quo_fix, rem_fix;
  logic               last;

  assign a_neg = ~op_i[0] & a_i[WIDTH-1];
  assign b_neg = ~op_i[0] & b_i[WIDTH-1];
  assign a_abs = a_neg ? -a_i : a_i;
  assign b_abs = b_neg ? -b_i : b_i;

  // Multiply: multiplicand shifts left, multiplier shifts right, so the
  // accumulator is always in final alignment.
  assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_fix = neg_res_q ? -mul_sum : mul_sum;

  // Divide: acc_q holds {remainder, dividend/quotient}; divisor sits in mcand_q.
  assign rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};
  assign div_ok  = ~trial[WIDTH];
  assign rem_nx  = div_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx  = {acc_q[WIDTH-2:0], div_ok};
  assign quo_fix = dz_q ? '1 : (neg_res_q ? -quo_nx : quo_nx);
  assign rem_fix = dz_q ? a_raw_q : (neg_rem_q ? -rem_nx : rem_nx);

`ifdef MULDIV_EARLY_OUT_EN
  assign last = (cnt_q == CW'(1)) | (~is_div_q & (mplier_q[WIDTH-1:1] == '0));
`else
  assign last = (cnt_q == CW'(1));
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    a_raw_d   = a_raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !cancel_i) begin
          state_d   = CALC;
          cnt_d     = CW'(WIDTH);
          is_div_d  = op_i[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = op_i[1] & (b_i == '0);
          a_raw_d   = a_i;
          mplier_d  = b_abs;
          if (op_i[1]) begin
            acc_d   = {{WIDTH{1'b0}}, a_abs};
            mcand_d = {{WIDTH{1'b0}}, b_abs};
          end else begin
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, a_abs};
          end
        end else if (!start_i) begin
          if (wr_hi_i) hi_d = wdata_i;
          if (wr_lo_i) lo_d = wdata_i;
        end
      end
      CALC: begin
        if (cancel_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (is_div_q) begin
            acc_d = {rem_nx, quo_nx};
          end else begin
            acc_d    = mul_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
          end
          if (last) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
            if (is_div_q) begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end else begin
              hi_d = prod_fix[2*WIDTH-1:WIDTH];
              lo_d = prod_fix[WIDTH-1:0];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      a_raw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      a_raw_q   <= a_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
    end
  end

  assign busy_o  = (state_q == CALC);
  assign stall_o = busy_o & (start_i | hilo_rd_i | wr_hi_i | wr_lo_i);
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign state_o = state_q;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for the iterative multiply/divide unit and HI/LO registers in the pipelined MIPS core; sits beside the EX stage.
- Accepts MULT/MULTU/DIV/DIVU from decode, runs a one-bit-per-cycle shift-add multiplier or restoring divider, and writes HI/LO.
- Serves MFHI/MFLO/MTHI/MTLO and raises a pipeline stall while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; also the iteration count.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- start_i  in  1  EX holds a mul/div instruction
- op_i  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with start_i
- a_i  in  WIDTH  rs operand (multiplicand/dividend)
- b_i  in  WIDTH  rt operand (multiplier/divisor)
- cancel_i  in  1  flush of the issuing instruction; aborts an operation in flight
- hilo_rd_i  in  1  EX holds MFHI/MFLO
- wr_hi_i  in  1  MTHI
- wr_lo_i  in  1  MTLO
- wdata_i  in  WIDTH  MTHI/MTLO data
- busy_o  out  1  operation in flight
- stall_o  out  1  freeze IF..EX
- done_o  out  1  one-cycle pulse after HI/LO update
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register

Behaviour:
- Reset (rst_ni=0 at clock edge): state IDLE, counter 0, hi_o=lo_o=0, busy_o=0, done_o=0. Reset mid-operation drops the operation; HI/LO are cleared.
- States are IDLE and CALC.
- IDLE, start_i=1, cancel_i=0:
  - Latch op_i.
  - Signed ops latch |a_i| and |b_i|, plus result-sign flags (quotient/product sign = sign(a) XOR sign(b); remainder sign = sign(a)).
  - Load counter=WIDTH and go to CALC.
- CALC:
  - Each edge performs one iteration and decrements the counter.
  - Multiply: 2*WIDTH-bit accumulator; add the shifted multiplicand when the current multiplier bit is 1.
  - Divide: restoring; shift remainder, trial-subtract the divisor, set a quotient bit.
- Final iteration edge (counter==1):
  - Apply sign correction (two's-complement negate, wrap allowed).
  - Multiply writes HI = product[2W-1:W] and LO = product[W-1:0].
  - Divide writes LO = quotient and HI = remainder.
  - Return to IDLE; done_o=1 for the next cycle only.
- Latency: the accept edge plus WIDTH CALC edges. busy_o is high for exactly WIDTH cycles. New HI/LO are visible in the cycle after the final edge.
- Divide by zero (b==0, any divide): full latency. Result LO = all ones, HI = a_i as issued (unsigned view of the original operand), regardless of sign.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wrap, no trap).
- stall_o = busy_o & (start_i | hilo_rd_i | wr_hi_i | wr_lo_i). It is combinational and deasserts in the cycle done_o is high.
- start_i while busy_o is not accepted. Decode stays stalled and re-presents the instruction.
- cancel_i in CALC: go to IDLE next edge, HI/LO unchanged, no done_o. cancel_i together with start_i in IDLE: start ignored.
- MTHI/MTLO apply only in IDLE, at the edge, with no stall. wr_hi_i and wr_lo_i may both be active.
- start_i and a write in the same IDLE cycle: start wins and the write is dropped. Decode never issues both.
- hi_o/lo_o are direct register outputs; MFHI/MFLO read them combinationally once not stalled.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined, multiply ops only:
  - Once the remaining unconsumed multiplier bits are all zero, finish on that edge: shift the accumulator into final alignment, write HI/LO, pulse done_o.
  - busy_o length = max(1, index of highest set bit of |b| + 1) cycles; b==0 gives 1 cycle.
  - Divide latency is unchanged.
- Undefined: all multiplies take exactly WIDTH cycles.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy_o high 32 cycles, then HI=0xFFFFFFFE, LO=0x00000001, done_o one-cycle pulse.
- MULT a=0xFFFFFFFD (-3) b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; with MULDIV_EARLY_OUT_EN, busy_o 3 cycles.
- DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=100 b=0 -> LO=0xFFFFFFFF, HI=100.
- MTHI 0x1234 and MTLO 0x5678 in the same IDLE cycle, then MFHI -> hi_o=0x1234, lo_o=0x5678, stall_o=0.
- DIVU issued, hilo_rd_i asserted 5 cycles later -> stall_o=1 until done_o cycle; start_i during busy not accepted.
- MULTU issued, cancel_i at cycle 10 -> IDLE next cycle, HI/LO keep prior values, no done_o. rst_ni=0 mid-op -> HI=LO=0, busy_o=0.
